// File: rtl/img_pkg.sv
// Shared types and helpers for the image frame buffer.
// Holds the default frame geometry, the pixel type for that geometry,
// the stream FSM state encoding and raster-index helpers.
package img_pkg;

  localparam int IMG_HEIGHT = 30;
  localparam int IMG_WIDTH  = 30;
  localparam int IMG_BPP    = 3;
  localparam int IMG_DW     = 8 * IMG_BPP;

  // One pixel at the default bytes-per-pixel setting.
  typedef logic [IMG_DW-1:0] pixel_t;

  // Raster readout controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } stream_state_e;

  // Raster index of (row, col) in a frame of the given width.
  function automatic int raster_index(input int row, input int col, input int width);
    return row * width + col;
  endfunction

  // Raster index of the bottom-right pixel.
  function automatic int last_index(input int height, input int width);
    return raster_index(height - 1, width - 1, width);
  endfunction

endpackage

// File: rtl/img_frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
// The read register only updates when re is high, so a stalled consumer
// sees its data held. Contents are not reset.
module img_frame_ram #(
  parameter int DW    = 24,
  parameter int DEPTH = 900,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, holds its value while re is low.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/img_frame_buf.sv
// Image frame buffer: address-written frame store with 1-cycle random
// reads and a raster-order valid/ready stream with sof/eol/eof markers.
// Optional feature macro: FRAME_BUF_PINGPONG_EN (two banks, writer and
// reader, swapped on frame completion). Without it a single bank is used
// and wr_ready is tied high.
//
// Stream handshake: a beat transfers on a rising edge where m_valid and
// m_ready are both high. Once m_valid is high, m_data and the markers stay
// stable until that transfer; m_valid never drops without a transfer
// (except under reset).
module img_frame_buf
  import img_pkg::*;
#(
  parameter int  HEIGHT = IMG_HEIGHT,
  parameter int  WIDTH  = IMG_WIDTH,
  parameter int  BPP    = IMG_BPP,
  localparam int DW     = 8 * BPP,
  localparam int PIXELS = HEIGHT * WIDTH,
  localparam int AW     = $clog2(PIXELS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          write_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] write_data,
  output logic          wr_ready,
  output logic          frame_done,
  input  logic          read_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] read_data,
  output logic          rd_valid,
  input  logic          stream_start,
  output logic          stream_busy,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_sof,
  output logic          m_eol,
  output logic          m_eof,
  output stream_state_e stream_state
);

  localparam int            CW        = $clog2(WIDTH);
  localparam int            RW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [AW:0]   PIX_LIM   = PIXELS[AW:0];
  localparam logic [AW-1:0] ADDR_LAST = AW'(last_index(HEIGHT, WIDTH));
  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);

  stream_state_e state, state_nx;
  logic          fetch;
  logic [AW-1:0] fetch_addr;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          m_valid_q, sof_q, eol_q, eof_q;
  logic          beat_done;

  logic [AW-1:0] wr_cnt;
  logic          wr_in_range, wr_accept, frame_complete;
  logic          rd_in_range, rd_fire;
  logic          rd_valid_q, rd_oor_q;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_q;

  assign stream_busy    = (state != ST_IDLE);
  assign stream_state   = state;
  assign wr_in_range    = ({1'b0, wr_addr} < PIX_LIM);
  assign rd_in_range    = ({1'b0, rd_addr} < PIX_LIM);
  assign wr_accept      = write_en && wr_ready && wr_in_range;
  assign frame_complete = wr_accept && (wr_cnt == ADDR_LAST);
  assign rd_fire        = read_en && !stream_busy && rd_in_range;
  assign beat_done      = m_valid_q && m_ready;
  // The single read port belongs to the stream while it runs.
  assign ram_re         = fetch || rd_fire;
  assign ram_raddr      = stream_busy ? fetch_addr : rd_addr;

`ifdef FRAME_BUF_PINGPONG_EN
  logic          wr_bank, swap_pending, swap_now, q_bank;
  logic [DW-1:0] q0, q1;

  assign wr_ready = !swap_pending;
  assign ram_q    = q_bank ? q1 : q0;
  // Swap immediately when idle; otherwise hold the writer off until the
  // stream finishes and swap on the edge that returns the FSM to idle.
  assign swap_now = ((state == ST_IDLE) && (frame_complete || swap_pending)) ||
                    (swap_pending && (state == ST_DRAIN) && (state_nx == ST_IDLE));

  img_frame_ram #(.DW(DW), .DEPTH(PIXELS), .AW(AW)) u_ram0 (
    .clk(clk), .we(wr_accept && !wr_bank), .waddr(wr_addr), .wdata(write_data),
    .re(ram_re), .raddr(ram_raddr), .rdata(q0)
  );

  img_frame_ram #(.DW(DW), .DEPTH(PIXELS), .AW(AW)) u_ram1 (
    .clk(clk), .we(wr_accept && wr_bank), .waddr(wr_addr), .wdata(write_data),
    .re(ram_re), .raddr(ram_raddr), .rdata(q1)
  );

  // Write counter, bank ownership and reader-bank frame_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt       <= '0;
      frame_done   <= 1'b0;
      wr_bank      <= 1'b0;
      swap_pending <= 1'b0;
      q_bank       <= 1'b0;
    end else begin
      if (wr_accept) wr_cnt <= frame_complete ? '0 : wr_cnt + 1'b1;
      if (frame_complete && (state != ST_IDLE)) swap_pending <= 1'b1;
      if (swap_now) begin
        wr_bank      <= ~wr_bank;
        frame_done   <= 1'b1;
        swap_pending <= 1'b0;
      end
      if (ram_re) q_bank <= ~wr_bank;
    end
  end
`else
  assign wr_ready = 1'b1;

  img_frame_ram #(.DW(DW), .DEPTH(PIXELS), .AW(AW)) u_ram (
    .clk(clk), .we(wr_accept), .waddr(wr_addr), .wdata(write_data),
    .re(ram_re), .raddr(ram_raddr), .rdata(ram_q)
  );

  // Write counter and frame_done: set on the last pixel, cleared by the next write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt     <= '0;
      frame_done <= 1'b0;
    end else if (wr_accept) begin
      wr_cnt     <= frame_complete ? '0 : wr_cnt + 1'b1;
      frame_done <= frame_complete;
    end
  end
`endif

  // Stream FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Stream FSM next state; a fetch happens whenever the output slot is free.
  always_comb begin
    state_nx = state;
    fetch    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (stream_start && frame_done) state_nx = ST_STREAM;
      end
      ST_STREAM: begin
        fetch = !m_valid_q || m_ready;
        if (fetch && (fetch_addr == ADDR_LAST)) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (beat_done && eof_q) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Raster fetch counters: linear address plus column/row position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_addr <= '0;
      col        <= '0;
      row        <= '0;
    end else if (state == ST_IDLE) begin
      fetch_addr <= '0;
      col        <= '0;
      row        <= '0;
    end else if (fetch) begin
      fetch_addr <= fetch_addr + 1'b1;
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Output beat register: valid and markers travel with the fetched pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_q <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
    end else if (fetch) begin
      m_valid_q <= 1'b1;
      sof_q     <= (fetch_addr == '0);
      eol_q     <= (col == COL_LAST);
      eof_q     <= (col == COL_LAST) && (row == ROW_LAST);
    end else if (m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  // Random-read response tracking; out-of-range reads answer with zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
    end else begin
      rd_valid_q <= read_en && !stream_busy;
      rd_oor_q   <= !rd_in_range;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign read_data = (rd_valid_q && !rd_oor_q) ? ram_q : '0;
  assign m_valid   = m_valid_q;
  assign m_data    = m_valid_q ? ram_q : '0;
  assign m_sof     = m_valid_q && sof_q;
  assign m_eol     = m_valid_q && eol_q;
  assign m_eof     = m_valid_q && eof_q;

endmodule

// File: tb/tb_img_frame_buf.sv
// Testbench for img_frame_buf (HEIGHT=3, WIDTH=4, BPP=3).
// Reference model: frame images held as plain arrays, stream expectations
// built from raster arithmetic into a queue. Build with
// FRAME_BUF_PINGPONG_EN defined to also cover the two-bank variant.
module tb_img_frame_buf;
  import img_pkg::*;

  localparam int HEIGHT = 3;
  localparam int WIDTH  = 4;
  localparam int BPP    = 3;
  localparam int DW     = 8 * BPP;
  localparam int PIX    = HEIGHT * WIDTH;
  localparam int AW     = $clog2(PIX);
`ifdef FRAME_BUF_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst, write_en, read_en, stream_start, m_ready;
  logic [AW-1:0] wr_addr, rd_addr;
  pixel_t        write_data, read_data, m_data;
  logic          wr_ready, frame_done, rd_valid, stream_busy;
  logic          m_valid, m_sof, m_eol, m_eof;
  stream_state_e stream_state;

  always #5 clk = ~clk;

  img_frame_buf #(.HEIGHT(HEIGHT), .WIDTH(WIDTH), .BPP(BPP)) dut (
    .clk(clk), .rst(rst),
    .write_en(write_en), .wr_addr(wr_addr), .write_data(write_data),
    .wr_ready(wr_ready), .frame_done(frame_done),
    .read_en(read_en), .rd_addr(rd_addr), .read_data(read_data), .rd_valid(rd_valid),
    .stream_start(stream_start), .stream_busy(stream_busy),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof), .stream_state(stream_state)
  );

  // ---------------- scoreboard / model ----------------
  int              vectors = 0;
  int              miscompares = 0;
  logic [DW+2:0]   exp_q[$];
  pixel_t          img [2][PIX];
  int              wb, wcnt;
  bit              done, pend, mdl_busy;
  int              perm [PIX];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    wb = 0; wcnt = 0; done = 0; pend = 0; mdl_busy = 0;
  endtask

  // Apply one write to the model using the frame rules (range, count, swap).
  task automatic model_write(input int a, input pixel_t d);
    if (a >= PIX || pend) return;
    img[wb][a] = d;
    wcnt++;
    if (wcnt == PIX) begin
      wcnt = 0;
      if (!PP) done = 1;
      else if (mdl_busy) pend = 1;
      else begin wb ^= 1; done = 1; end
    end else if (!PP) begin
      done = 0;
    end
  endtask

  function automatic pixel_t rd_img(input int a);
    if (a >= PIX) return '0;
    return PP ? img[wb ^ 1][a] : img[wb][a];
  endfunction

  task automatic make_perm();
    for (int i = 0; i < PIX; i++) perm[i] = i;
    for (int i = PIX - 1; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_px(input int a, input pixel_t d);
    write_en = 1'b1; wr_addr = AW'(a); write_data = d;
    model_write(a, d);
    tick();
    write_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; write_en = 0; read_en = 0; stream_start = 0; m_ready = 0;
    wr_addr = '0; rd_addr = '0; write_data = '0;
    model_reset();
    tick(); tick();
    vectors++;
    if ({wr_ready, frame_done, rd_valid, stream_busy, m_valid, m_sof, m_eol, m_eof} !== 8'b1000_0000) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 10000000",
               {wr_ready, frame_done, rd_valid, stream_busy, m_valid, m_sof, m_eol, m_eof});
    end
    vectors++;
    if (read_data !== '0 || m_data !== '0 || stream_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL reset_data read_data=%h m_data=%h state=%0d want 0/0/0", read_data, m_data, stream_state);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_write_frame();
    for (int i = 0; i < PIX; i++) begin
      write_px(i, pixel_t'(32'h000100 + i));
      vectors++;
      if (frame_done !== done) begin
        miscompares++;
        $display("FAIL write_frame_done after write %0d got %b want %b", i, frame_done, done);
      end
    end
  endtask

  task automatic test_random_read(input int first_addr, input int n);
    int prev;
    read_en = 1'b1; rd_addr = AW'(first_addr); prev = first_addr;
    tick();
    for (int k = 0; k < n; k++) begin
      vectors++;
      if (rd_valid !== 1'b1 || read_data !== rd_img(prev)) begin
        miscompares++;
        $display("FAIL random_read addr=%0d got v=%b d=%h want v=1 d=%h", prev, rd_valid, read_data, rd_img(prev));
      end
      prev = $urandom_range(0, (1 << AW) - 1);
      rd_addr = AW'(prev);
      tick();
    end
    read_en = 1'b0;
    tick();
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL read_idle rd_valid got %b want 0", rd_valid);
    end
  endtask

  task automatic test_out_of_range_write();
    write_px(PIX, pixel_t'($urandom));
    vectors++;
    if (frame_done !== done) begin
      miscompares++;
      $display("FAIL oor_write frame_done got %b want %b", frame_done, done);
    end
    make_perm();
    for (int i = 0; i < PIX; i++) begin
      write_px(perm[i], pixel_t'($urandom));
      vectors++;
      if (frame_done !== done) begin
        miscompares++;
        $display("FAIL oor_refill_done write %0d got %b want %b", i, frame_done, done);
      end
    end
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1; 2: random ready; 3: ready every third cycle
  task automatic run_stream(input int mode, input bit write_b, input bit probe_rd);
    int     cyc, first_v, wi;
    bit     held_v, r;
    pixel_t held_d;
    logic [DW+2:0] got, want;
    exp_q.delete();
    for (int i = 0; i < PIX; i++)
      exp_q.push_back({rd_img(i), i == 0, (i % WIDTH) == WIDTH - 1, i == PIX - 1});
    stream_start = 1'b1;
    tick();
    stream_start = 1'b0;
    mdl_busy = 1;
    vectors++;
    if (m_valid !== 1'b0 || stream_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stream_enter valid=%b busy=%b want 0/1", m_valid, stream_busy);
    end
    cyc = 0; first_v = -1; held_v = 0; held_d = '0; wi = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       r = 1'($urandom_range(0, 1));
        default: r = (cyc % 3 == 0);
      endcase
      m_ready = r;
      if (m_valid && first_v < 0) first_v = cyc;
      vectors++;
      if (stream_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_busy cyc %0d got %b want 1", cyc, stream_busy);
      end
      if (held_v) begin
        vectors++;
        if (m_valid !== 1'b1 || m_data !== held_d) begin
          miscompares++;
          $display("FAIL stall_hold cyc %0d got v=%b d=%h want v=1 d=%h", cyc, m_valid, m_data, held_d);
        end
      end
      if (probe_rd) begin
        vectors++;
        if (rd_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL read_during_stream cyc %0d rd_valid got %b want 0", cyc, rd_valid);
        end
        read_en = 1'b1;
        rd_addr = AW'($urandom_range(0, PIX - 1));
      end
      if (write_b && wi <= PIX) begin
        vectors++;
        if (wr_ready !== !pend) begin
          miscompares++;
          $display("FAIL wr_ready_during_stream cyc %0d got %b want %b", cyc, wr_ready, !pend);
        end
        write_en = 1'b1; wr_addr = AW'(wi % PIX); write_data = pixel_t'($urandom);
        model_write(wi % PIX, write_data);
        wi++;
      end else begin
        write_en = 1'b0;
      end
      if (m_valid && r) begin
        got  = {m_data, m_sof, m_eol, m_eof};
        want = exp_q.pop_front();
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL stream_beat %0d got %h want %h (data,sof,eol,eof)", PIX - 1 - exp_q.size(), got, want);
        end
        if (exp_q.size() == 0) begin
          mdl_busy = 0;
          if (pend) begin wb ^= 1; done = 1; pend = 0; end
        end
      end
      held_v = m_valid && !r;
      held_d = m_data;
      tick();
      cyc++;
    end
    write_en = 1'b0; read_en = 1'b0; m_ready = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stream_timeout beats left %0d want 0", exp_q.size());
    end
    vectors++;
    if (stream_busy !== 1'b0 || m_valid !== 1'b0 || wr_ready !== 1'b1 || frame_done !== done) begin
      miscompares++;
      $display("FAIL stream_exit busy=%b valid=%b wr_ready=%b done=%b want 0/0/1/%b",
               stream_busy, m_valid, wr_ready, frame_done, done);
    end
    if (mode == 0) begin
      vectors++;
      if (first_v != 1 || cyc != PIX + 1) begin
        miscompares++;
        $display("FAIL stream_timing first_valid_cyc=%0d total=%0d want 1/%0d", first_v, cyc, PIX + 1);
      end
    end
  endtask

  task automatic test_final_write_with_start();
    make_perm();
    for (int i = 0; i < PIX - 1; i++) write_px(perm[i], pixel_t'($urandom));
    write_en = 1'b1; wr_addr = AW'(perm[PIX-1]); write_data = pixel_t'($urandom);
    stream_start = 1'b1;
    model_write(perm[PIX-1], write_data);
    tick();
    write_en = 1'b0; stream_start = 1'b0;
    vectors++;
    if (stream_busy !== 1'b0 || frame_done !== done) begin
      miscompares++;
      $display("FAIL final_write_start busy=%b done=%b want 0/%b", stream_busy, frame_done, done);
    end
  endtask

  task automatic test_reset_mid_stream();
    stream_start = 1'b1; m_ready = 1'b1;
    tick();
    stream_start = 1'b0;
    repeat (7) tick();
    vectors++;
    if (m_valid !== 1'b1 || m_data !== rd_img(6)) begin
      miscompares++;
      $display("FAIL mid_stream_beat6 got v=%b d=%h want v=1 d=%h", m_valid, m_data, rd_img(6));
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (m_valid !== 1'b0 || frame_done !== 1'b0 || stream_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset valid=%b done=%b busy=%b want 0/0/0", m_valid, frame_done, stream_busy);
    end
    m_ready = 1'b0;
    tick();
    rst = 1'b1;
    model_reset();
    stream_start = 1'b1;
    tick();
    stream_start = 1'b0;
    tick();
    vectors++;
    if (stream_busy !== 1'b0 || m_valid !== 1'b0 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL start_after_reset busy=%b valid=%b done=%b want 0/0/0", stream_busy, m_valid, frame_done);
    end
  endtask

`ifdef FRAME_BUF_PINGPONG_EN
  task automatic test_pingpong();
    for (int i = 0; i < PIX; i++) write_px(i, pixel_t'($urandom));
    vectors++;
    if (frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL pp_frame_a_done got %b want 1", frame_done);
    end
    run_stream(3, 1'b1, 1'b0);
    run_stream(0, 1'b0, 1'b0);
    test_random_read($urandom_range(0, PIX - 1), 6);
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_write_frame();
    test_random_read(5, 20);
    test_out_of_range_write();
    test_random_read(PIX, 20);
    run_stream(0, 1'b0, 1'b0);
    run_stream(1, 1'b0, 1'b0);
    run_stream(2, 1'b0, 1'b1);
    test_final_write_with_start();
    run_stream(0, 1'b0, 1'b0);
    test_reset_mid_stream();
`ifdef FRAME_BUF_PINGPONG_EN
    test_pingpong();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
